// File: rtl/uart_boot_loader_if.sv
// Boot-loader signal bundle.
// Groups the UART input, the loader enable, the received-byte stream, the
// program-memory write port and the loader status flags.
//   master : the boot loader (drives byte stream, write port and status)
//   slave  : the environment (drives rx_i and en, observes the rest)
interface uart_boot_loader_if #(
  parameter int ADDR_W = 8
);
  logic              rx_i;
  logic              en;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              frame_err;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              load_active;
  logic              done;
  logic              err;

  modport master (
    input  rx_i, en,
    output byte_valid, byte_data, frame_err,
    output wr_en, wr_addr, wr_data,
    output load_active, done, err
  );

  modport slave (
    output rx_i, en,
    input  byte_valid, byte_data, frame_err,
    input  wr_en, wr_addr, wr_data,
    input  load_active, done, err
  );
endinterface

// File: rtl/uart_boot_loader.sv
// UART boot loader for the P_Risc program memory.
// An 8N1 receiver samples each bit in its middle and reports good bytes
// (byte_valid/byte_data) or bad stop bits (frame_err). The loader FSM takes
// a count byte N followed by N little-endian 32-bit words and writes them to
// consecutive word addresses starting at 0.
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : uart_boot_loader_if.master (rx_i, en in; byte stream, memory
//          write port wr_en/wr_addr/wr_data, load_active/done/err out)
module uart_boot_loader #(
  parameter int CLKS_PER_BIT = 87,
  parameter int ADDR_W       = 8
) (
  input  logic                clk,
  input  logic                rst,
  uart_boot_loader_if.master  bus
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [2:0] {L_IDLE, L_COUNT, L_WORD, L_DONE, L_ERR} ld_state_t;

  // Synchronizer and receiver state
  logic             rx_m, rx_s;
  rx_state_t        rstate, rstate_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shreg, shreg_n;
  logic             byte_valid_q, byte_valid_n;
  logic             frame_err_q, frame_err_n;
  logic [7:0]       byte_data_q, byte_data_n;

  // Loader state
  ld_state_t         lstate, lstate_n;
  logic [7:0]        count, count_n;
  logic [7:0]        words, words_n;
  logic [1:0]        idx, idx_n;
  logic [23:0]       word_buf, word_buf_n;
  logic              wr_en_q, wr_en_n;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_n;
  logic [31:0]       wr_data_q, wr_data_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m         <= 1'b1;
      rx_s         <= 1'b1;
      rstate       <= R_IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      shreg        <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      byte_data_q  <= '0;
      lstate       <= L_IDLE;
      count        <= '0;
      words        <= '0;
      idx          <= '0;
      word_buf     <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      rx_m         <= bus.rx_i;
      rx_s         <= rx_m;
      rstate       <= rstate_n;
      cnt          <= cnt_n;
      bit_idx      <= bit_idx_n;
      shreg        <= shreg_n;
      byte_valid_q <= byte_valid_n;
      frame_err_q  <= frame_err_n;
      byte_data_q  <= byte_data_n;
      lstate       <= lstate_n;
      count        <= count_n;
      words        <= words_n;
      idx          <= idx_n;
      word_buf     <= word_buf_n;
      wr_en_q      <= wr_en_n;
      wr_addr_q    <= wr_addr_n;
      wr_data_q    <= wr_data_n;
    end
  end

  // Receiver: start bit is re-checked at half a bit, so every later sample
  // lands in the middle of its bit cell.
  always_comb begin
    rstate_n     = rstate;
    cnt_n        = cnt;
    bit_idx_n    = bit_idx;
    shreg_n      = shreg;
    byte_valid_n = 1'b0;
    frame_err_n  = 1'b0;
    byte_data_n  = byte_data_q;
    case (rstate)
      R_IDLE: begin
        if (!rx_s) begin
          rstate_n = R_START;
          cnt_n    = '0;
        end
      end
      R_START: begin
        if (cnt == HALF_LAST) begin
          cnt_n     = '0;
          bit_idx_n = '0;
          rstate_n  = rx_s ? R_IDLE : R_DATA;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      R_DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_n     = '0;
          shreg_n   = {rx_s, shreg[7:1]};
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) rstate_n = R_STOP;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      R_STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_n    = '0;
          rstate_n = R_IDLE;
          if (rx_s) begin
            byte_valid_n = 1'b1;
            byte_data_n  = shreg;
          end else begin
            frame_err_n = 1'b1;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: rstate_n = R_IDLE;
    endcase
  end

  // Loader: the write strobe is registered; the address/word-count bump
  // happens in the cycle the strobe is visible so wr_addr matches wr_en.
  always_comb begin
    lstate_n   = lstate;
    count_n    = count;
    words_n    = words;
    idx_n      = idx;
    word_buf_n = word_buf;
    wr_en_n    = 1'b0;
    wr_addr_n  = wr_addr_q;
    wr_data_n  = wr_data_q;
    if (!bus.en) begin
      lstate_n = L_IDLE;
    end else begin
      case (lstate)
        L_IDLE: begin
          lstate_n  = L_COUNT;
          words_n   = '0;
          idx_n     = '0;
          wr_addr_n = '0;
        end
        L_COUNT: begin
          if (frame_err_q) begin
            lstate_n = L_ERR;
          end else if (byte_valid_q) begin
            count_n  = byte_data_q;
            lstate_n = (byte_data_q == 8'd0) ? L_DONE : L_WORD;
          end
        end
        L_WORD: begin
          if (wr_en_q) begin
            wr_addr_n = wr_addr_q + ADDR_W'(1);
            words_n   = words + 8'd1;
            if (words + 8'd1 == count) lstate_n = L_DONE;
          end
          if (frame_err_q) begin
            lstate_n = L_ERR;
          end else if (byte_valid_q) begin
            idx_n = idx + 2'd1;
            case (idx)
              2'd0:    word_buf_n[7:0]   = byte_data_q;
              2'd1:    word_buf_n[15:8]  = byte_data_q;
              2'd2:    word_buf_n[23:16] = byte_data_q;
              default: begin
                wr_en_n   = 1'b1;
                wr_data_n = {byte_data_q, word_buf};
              end
            endcase
          end
        end
        L_DONE, L_ERR: lstate_n = lstate;
        default:       lstate_n = L_IDLE;
      endcase
    end
  end

  assign bus.byte_valid  = byte_valid_q;
  assign bus.byte_data   = byte_data_q;
  assign bus.frame_err   = frame_err_q;
  assign bus.wr_en       = wr_en_q;
  assign bus.wr_addr     = wr_addr_q;
  assign bus.wr_data     = wr_data_q;
  assign bus.load_active = (lstate == L_COUNT) || (lstate == L_WORD);
  assign bus.done        = (lstate == L_DONE);
  assign bus.err         = (lstate == L_ERR);

endmodule

// File: tb/tb_uart_boot_loader.sv
// Testbench for uart_boot_loader: table of single-byte frames plus
// hand-written load, glitch, framing-error, abort and reset sequences.
// Expected bytes, frame errors and memory writes go into a scoreboard queue
// when stimulus is driven and are popped as the DUT reports them.
module tb_uart_boot_loader;
  localparam int CPB    = 8;
  localparam int ADDR_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_boot_loader_if #(.ADDR_W(ADDR_W)) bus ();

  uart_boot_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          kind;   // 0 byte, 1 frame error, 2 memory write
    logic [31:0] data;
    logic [7:0]  addr;
  } ev_t;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic [7:0] exp_hold;
  } vec_t;

  ev_t  sb[$];
  vec_t vecs[5];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop);
    bus.rx_i = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      bus.rx_i = d[i];
      repeat (CPB) tick();
    end
    bus.rx_i = stop;
    repeat (CPB) tick();
    bus.rx_i = 1'b1;
  endtask

  function automatic void exp_byte(input logic [7:0] d);
    ev_t e;
    e.kind = 0; e.data = {24'd0, d}; e.addr = '0;
    sb.push_back(e);
  endfunction

  function automatic void exp_fe();
    ev_t e;
    e.kind = 1; e.data = '0; e.addr = '0;
    sb.push_back(e);
  endfunction

  function automatic void exp_wr(input logic [7:0] a, input logic [31:0] d);
    ev_t e;
    e.kind = 2; e.data = d; e.addr = a;
    sb.push_back(e);
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin
    ev_t e;
    if (!rst) begin
      if (bus.byte_valid) begin
        if (sb.size() == 0) check("unexpected_byte_valid", {24'd0, bus.byte_data}, 32'hFFFF_FFFF);
        else begin
          e = sb.pop_front();
          check("event_kind_byte", 32'(e.kind), 32'd0);
          check("byte_data", {24'd0, bus.byte_data}, e.data);
        end
      end
      if (bus.frame_err) begin
        if (sb.size() == 0) check("unexpected_frame_err", 32'd1, 32'd0);
        else begin
          e = sb.pop_front();
          check("event_kind_fe", 32'(e.kind), 32'd1);
        end
      end
      if (bus.wr_en) begin
        if (sb.size() == 0) check("unexpected_wr_en", bus.wr_data, 32'hFFFF_FFFF);
        else begin
          e = sb.pop_front();
          check("event_kind_wr", 32'(e.kind), 32'd2);
          check("wr_addr", {24'd0, bus.wr_addr}, {24'd0, e.addr});
          check("wr_data", bus.wr_data, e.data);
        end
      end
    end
  end

  initial begin
    vecs[0] = '{data: 8'hA5, stop: 1'b1, exp_hold: 8'hA5};
    vecs[1] = '{data: 8'h00, stop: 1'b1, exp_hold: 8'h00};
    vecs[2] = '{data: 8'hFF, stop: 1'b1, exp_hold: 8'hFF};
    vecs[3] = '{data: 8'h5A, stop: 1'b0, exp_hold: 8'hFF};
    vecs[4] = '{data: 8'h3C, stop: 1'b1, exp_hold: 8'h3C};

    bus.rx_i = 1'b1;
    bus.en   = 1'b0;
    repeat (4) tick();
    check("rst_byte_valid",  {31'd0, bus.byte_valid},  32'd0);
    check("rst_byte_data",   {24'd0, bus.byte_data},   32'd0);
    check("rst_frame_err",   {31'd0, bus.frame_err},   32'd0);
    check("rst_wr_en",       {31'd0, bus.wr_en},       32'd0);
    check("rst_wr_addr",     {24'd0, bus.wr_addr},     32'd0);
    check("rst_wr_data",     bus.wr_data,              32'd0);
    check("rst_load_active", {31'd0, bus.load_active}, 32'd0);
    check("rst_done",        {31'd0, bus.done},        32'd0);
    check("rst_err",         {31'd0, bus.err},         32'd0);
    rst = 1'b0;
    repeat (3) tick();

    // Single frames with the loader disabled
    for (int v = 0; v < 5; v++) begin
      if (vecs[v].stop) exp_byte(vecs[v].data);
      else exp_fe();
      send_byte(vecs[v].data, vecs[v].stop);
      repeat (4) tick();
      check("hold_byte_data", {24'd0, bus.byte_data}, {24'd0, vecs[v].exp_hold});
      check("idle_no_load", {31'd0, bus.load_active}, 32'd0);
    end

    // Two-word program load
    bus.en = 1'b1;
    repeat (2) tick();
    check("load_active_count", {31'd0, bus.load_active}, 32'd1);
    exp_byte(8'h02);
    send_byte(8'h02, 1'b1);
    foreach (vecs[k]) begin end
    exp_byte(8'h78); send_byte(8'h78, 1'b1);
    exp_byte(8'h56); send_byte(8'h56, 1'b1);
    exp_byte(8'h34); send_byte(8'h34, 1'b1);
    exp_byte(8'h12); exp_wr(8'd0, 32'h1234_5678); send_byte(8'h12, 1'b1);
    exp_byte(8'hEF); send_byte(8'hEF, 1'b1);
    exp_byte(8'hBE); send_byte(8'hBE, 1'b1);
    exp_byte(8'hAD); send_byte(8'hAD, 1'b1);
    exp_byte(8'hDE); exp_wr(8'd1, 32'hDEAD_BEEF); send_byte(8'hDE, 1'b1);
    repeat (10) tick();
    check("load_done",        {31'd0, bus.done},        32'd1);
    check("load_active_done", {31'd0, bus.load_active}, 32'd0);
    check("load_wr_addr",     {24'd0, bus.wr_addr},     32'd2);
    // Byte in L_DONE: still reported, not written
    exp_byte(8'h11);
    send_byte(8'h11, 1'b1);
    repeat (4) tick();
    check("done_holds", {31'd0, bus.done}, 32'd1);
    bus.en = 1'b0;
    repeat (2) tick();
    check("done_cleared", {31'd0, bus.done}, 32'd0);

    // Glitch shorter than half a bit
    bus.rx_i = 1'b0;
    repeat (2) tick();
    bus.rx_i = 1'b1;
    repeat (20) tick();
    exp_byte(8'h3C);
    send_byte(8'h3C, 1'b1);
    repeat (4) tick();
    check("glitch_then_byte", {24'd0, bus.byte_data}, 32'h3C);

    // Framing error during a load
    bus.en = 1'b1;
    repeat (2) tick();
    exp_byte(8'h01); send_byte(8'h01, 1'b1);
    exp_fe();        send_byte(8'h99, 1'b0);
    repeat (4) tick();
    check("fe_err",         {31'd0, bus.err},         32'd1);
    check("fe_load_active", {31'd0, bus.load_active}, 32'd0);
    bus.en = 1'b0;
    repeat (2) tick();
    check("fe_err_cleared", {31'd0, bus.err}, 32'd0);

    // Abort after two bytes of a word, then an empty image
    bus.en = 1'b1;
    repeat (2) tick();
    exp_byte(8'h01); send_byte(8'h01, 1'b1);
    exp_byte(8'h11); send_byte(8'h11, 1'b1);
    exp_byte(8'h22); send_byte(8'h22, 1'b1);
    bus.en = 1'b0;
    repeat (2) tick();
    check("abort_idle", {31'd0, bus.load_active}, 32'd0);
    bus.en = 1'b1;
    repeat (2) tick();
    exp_byte(8'h00); send_byte(8'h00, 1'b1);
    repeat (4) tick();
    check("empty_done",    {31'd0, bus.done},    32'd1);
    check("empty_wr_addr", {24'd0, bus.wr_addr}, 32'd0);
    bus.en = 1'b0;
    repeat (2) tick();

    // Reset during the data bits of 0xFF
    bus.rx_i = 1'b0;
    repeat (CPB) tick();
    bus.rx_i = 1'b1;
    repeat (2 * CPB) tick();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    repeat (10 * CPB) tick();
    check("rst_mid_byte_data", {24'd0, bus.byte_data}, 32'd0);
    exp_byte(8'h81);
    send_byte(8'h81, 1'b1);
    repeat (4) tick();
    check("after_rst_byte", {24'd0, bus.byte_data}, 32'h81);

    repeat (10) tick();
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_boot_loader.md
Name: uart_boot_loader

Overview:
- Upstream of the P_Risc core: receives the serial program image on the UART RX pin and writes assembled 32-bit instruction words into core program memory.
- Contains a mid-bit-sampling 8N1 UART receiver plus a loader FSM that parses a count byte followed by little-endian words.
- Raw bytes are also exported for a debug/echo path.

Parameters:
- CLKS_PER_BIT, 87, clock cycles per UART bit. Must be ≥ 4; half-bit = CLKS_PER_BIT/2, truncated.
- ADDR_W, 8, program-memory word-address width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- rx_i  in  1  raw asynchronous UART RX line; idle high.
- en  in  1  loader enable, level-sensitive.
- byte_valid  out  1  one-cycle pulse: a good byte was received.
- byte_data  out  8  last good byte; held between pulses.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- wr_en  out  1  one-cycle program-memory write strobe.
- wr_addr  out  ADDR_W  word address for wr_en.
- wr_data  out  32  word for wr_en.
- load_active  out  1  high in COUNT and WORD states.
- done  out  1  high while in L_DONE.
- err  out  1  high while in L_ERR.

Behaviour:
- Reset values:
  - All outputs 0.
  - Both synchronizer flops 1.
  - RX FSM in R_IDLE; loader in L_IDLE; counters 0.
- Synchronizer: two flops on rx_i, giving rx_s; 2-cycle latency. All RX decisions use rx_s only.
- RX FSM (runs regardless of en):
  - R_IDLE: rx_s==0 → R_START, cnt=0.
  - R_START: at cnt==CLKS_PER_BIT/2-1, if rx_s==0 → R_DATA (cnt=0, bit=0); else → R_IDLE (glitch rejected, no pulse).
  - R_DATA: at cnt==CLKS_PER_BIT-1, shift rx_s in LSB-first, cnt=0. After the 8th bit → R_STOP.
  - R_STOP: at cnt==CLKS_PER_BIT-1, sample rx_s.
    - rx_s==1: byte_valid=1 and byte_data updated on the next edge.
    - rx_s==0: frame_err=1 and byte_data unchanged.
    - Either way → R_IDLE. A new start bit is accepted from the following cycle, so back-to-back frames work.
- Latency: byte_valid rises CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 3 cycles (±1) after rx_i falls.
- Loader FSM:
  - L_IDLE: en==1 → L_COUNT; clear word count, byte index, and wr_addr to 0.
  - L_COUNT: on byte_valid, N=byte_data.
    - N==0 → L_DONE.
    - Otherwise → L_WORD.
  - L_WORD: each byte_valid fills byte lane idx (idx 0 → bits 7:0 … idx 3 → bits 31:24), then idx++.
    - On the 4th byte: wr_en pulses the next cycle with the assembled word and the current wr_addr. Then wr_addr++, idx=0, words++.
    - When words reaches N → L_DONE. wr_addr then holds N.
  - frame_err in L_COUNT or L_WORD → L_ERR. The partial word is discarded; no wr_en is issued.
  - L_DONE and L_ERR hold until en==0.
  - en==0 in any state → L_IDLE on the next edge. A partial word is discarded and any wr_en not yet issued is suppressed.
- Boundary conditions:
  - Bytes arriving in L_IDLE, L_DONE, or L_ERR are ignored by the loader but still pulse byte_valid.
  - wr_addr wraps modulo 2^ADDR_W if N > 2^ADDR_W−1. This cannot occur when ADDR_W=8.
  - rst mid-frame: the frame is dropped, with no byte_valid or frame_err.
  - A line held low (break): detected as frame_err. The receiver then returns to R_IDLE and immediately re-enters R_START; no further frame_err occurs until a full frame completes.

Test Plan:
- Single byte, CLKS_PER_BIT=8, en=0: send 0xA5 → one byte_valid with byte_data=0xA5; no wr_en; frame_err never asserted.
- Load, en=1: send 0x02, 78 56 34 12, EF BE AD DE →
  - wr_en at addr 0 with data 0x12345678;
  - wr_en at addr 1 with data 0xDEADBEEF;
  - then done=1, load_active=0, wr_addr=2.
- Glitch: rx_i low for 2 cycles, then high → no byte_valid, no frame_err; the RX FSM returns to R_IDLE. A following 0x3C is received correctly.
- Framing error: after count 0x01, send a byte with stop bit 0 → frame_err pulse, err=1, no wr_en. Dropping en → L_IDLE, err=0.
- Abort: en dropped after 2 bytes of a word → no wr_en. Re-raising en and sending count 0x00 → done=1 with no writes.
- Reset mid-frame: assert rst during the data bits of 0xFF → no pulses. A subsequent 0x81 → byte_valid with byte_data=0x81.
